// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Responder for a CPU instruction port and a CPU data port.
//               Serialises both onto a single backing-memory port, caches
//               the last completed result per port under a captured tag,
//               and answers combinationally while the CPU holds that tag.
//               Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN
//               to let a waiting fetch win after STARVE_LIMIT data grants.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    // Instruction port
    input  logic        instruction_request,
    input  logic [15:0] instruction_address,
    output logic [15:0] instr,
    output logic        instruction_response,

    // Data port
    input  logic        data_request,
    input  logic        write_enable,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_address,
    input  logic [15:0] write_data,
    output logic [15:0] mem_rdata,
    output logic        data_response,

    // Backing-memory port
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_address,
    output logic [15:0] pmem_wdata,
    output logic [1:0]  pmem_byte_enable,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_I_ACCESS = 2'd1;
    localparam logic [1:0] c_D_ACCESS = 2'd2;

    // Counter wide enough to hold STARVE_LIMIT itself (saturates there).
    localparam int                 c_CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_next_state;

    // Instruction port: completion flag, tag and result
    logic               r_i_done;
    logic [15:0]        r_i_addr;
    logic [15:0]        r_instr;

    // Data port: completion flag, tag and result
    logic               r_d_done;
    logic [15:0]        r_d_addr;
    logic               r_d_we;
    logic [1:0]         r_d_be;
    logic [15:0]        r_d_wdata;
    logic [15:0]        r_rdata;

    // Consecutive data grants taken while a fetch was waiting
    logic [c_CNT_W-1:0] r_starve_cnt;

    // ------------------------------------------------------------------------
    // Tag matching and pending detection
    // ------------------------------------------------------------------------
    logic w_i_match;
    logic w_d_match;
    logic w_i_pend;
    logic w_d_pend;
    logic w_starved;
    logic w_grant_i;
    logic w_grant_d;
    logic w_i_complete;
    logic w_d_complete;

    // A port is matched when its last access finished under exactly the
    // inputs the CPU is presenting now; only then is the stored result valid.
    assign w_i_match = r_i_done && (instruction_address == r_i_addr);
    assign w_d_match = r_d_done
                    && (mem_address     == r_d_addr)
                    && (write_enable    == r_d_we)
                    && (mem_byte_enable == r_d_be)
                    && (write_data      == r_d_wdata);

    assign w_i_pend = instruction_request && !w_i_match;
    assign w_d_pend = data_request        && !w_d_match;

    assign instruction_response = instruction_request && w_i_match;
    assign data_response        = data_request        && w_d_match;

    assign instr     = r_instr;
    assign mem_rdata = r_rdata;

`ifdef MEM_ARB_STARVE_GUARD_EN
    // The fetch port takes priority once data has won STARVE_LIMIT times.
    assign w_starved = (r_starve_cnt >= c_LIMIT);
`else
    // Strict data priority: the counter is never consulted.
    assign w_starved = 1'b0;
`endif

    // Arbitration only happens in IDLE; data wins ties unless starved.
    assign w_grant_i = (r_state == c_IDLE) && w_i_pend && (!w_d_pend || w_starved);
    assign w_grant_d = (r_state == c_IDLE) && w_d_pend && !(w_i_pend && w_starved);

    // pmem_resp is only meaningful while an access is in flight; a stray
    // response after a reset-abandoned access lands in IDLE and is dropped.
    assign w_i_complete = (r_state == c_I_ACCESS) && pmem_resp;
    assign w_d_complete = (r_state == c_D_ACCESS) && pmem_resp;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: grant from IDLE, return to IDLE on backing completion
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_grant_d) begin
                    w_next_state = c_D_ACCESS;
                end else if (w_grant_i) begin
                    w_next_state = c_I_ACCESS;
                end
            end
            c_I_ACCESS: begin
                if (pmem_resp) begin
                    w_next_state = c_IDLE;
                end
            end
            c_D_ACCESS: begin
                if (pmem_resp) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // Outputs: backing port driven purely from the captured tag, so a CPU
    // that flushes mid-access cannot disturb the transaction in flight.
    always_comb begin
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_address     = 16'h0000;
        pmem_wdata       = 16'h0000;
        pmem_byte_enable = 2'b00;
        case (r_state)
            c_I_ACCESS: begin
                pmem_read        = 1'b1;
                pmem_address     = r_i_addr;
                pmem_byte_enable = 2'b11;
            end
            c_D_ACCESS: begin
                pmem_read        = !r_d_we;
                pmem_write       = r_d_we;
                pmem_address     = r_d_addr;
                pmem_wdata       = r_d_wdata;
                pmem_byte_enable = r_d_be;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------

    // Tag capture on grant, result and done flag update on completion
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_i_done  <= 1'b0;
            r_i_addr  <= 16'h0000;
            r_instr   <= 16'h0000;
            r_d_done  <= 1'b0;
            r_d_addr  <= 16'h0000;
            r_d_we    <= 1'b0;
            r_d_be    <= 2'b00;
            r_d_wdata <= 16'h0000;
            r_rdata   <= 16'h0000;
        end else begin
            // A fresh grant invalidates the old result and latches the new tag.
            if (w_grant_i) begin
                r_i_done <= 1'b0;
                r_i_addr <= instruction_address;
            end
            if (w_grant_d) begin
                r_d_done  <= 1'b0;
                r_d_addr  <= mem_address;
                r_d_we    <= write_enable;
                r_d_be    <= mem_byte_enable;
                r_d_wdata <= write_data;
            end

            if (w_i_complete) begin
                r_i_done <= 1'b1;
                r_instr  <= pmem_rdata;
            end

            if (w_d_complete) begin
                r_d_done <= 1'b1;
                if (!r_d_we) begin
                    r_rdata <= pmem_rdata;
                end else if (r_d_addr == r_i_addr) begin
                    // Store hit the cached fetch word: force a refetch.
                    r_i_done <= 1'b0;
                end
            end
        end
    end

    // Starvation counter; tracked in every build, consulted only when guarded
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (!w_i_pend || w_grant_i) begin
            r_starve_cnt <= '0;
        end else if (w_grant_d && (r_starve_cnt != c_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire
